random_target_gen: RTL and testbench

- Upstream stage of the guess-comparison logic in the guess-the-number game.
- On a Start press, draws a pseudo-random target in −99..+99.
- Presents the target in sign/BCD form as rdm1 (tens), rdm0 (ones) and neg, which the guess comparator consumes directly.
- A free-running LFSR supplies entropy, so the target depends on how long the player waits before pressing Start.

---
 rtl/game_pkg.sv | 29 ++
 rtl/btn_sync_edge.sv | 33 +++
 rtl/random_target_gen.sv | 127 ++++++++++++
 tb/tb_random_target_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the guess-the-number datapath.
//   state_t         - draw FSM states of random_target_gen
//   bcd_t           - one BCD digit
//   MAX_MAG_DEFAULT - largest magnitude a draw may produce
//   LFSR_TAPS       - tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   lfsr_step()     - one LFSR advance, with recovery from the all-zero lock-up state
package game_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StConvert,
        StHold
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int unsigned MAX_MAG_DEFAULT = 99;
    localparam logic [15:0] LFSR_TAPS       = 16'hB400;

    // Fibonacci step: shift left, feedback enters at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur, input logic [15:0] seed);
        if (cur == 16'h0000) begin
            return seed;
        end
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser for an active-low push-button plus a
// falling-edge detector. Shared by the Start and Guess button paths.
//   clk   - system clock
//   rst_n - asynchronous active-low reset (all flops reset to 1 = released)
//   btn   - raw button, active-low, asynchronous to clk
//   fall  - one-cycle pulse when the synchronised button goes low
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic fall
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    // A held button gives one pulse: dly_q follows sync2_q low one cycle later.
    assign fall = dly_q & ~sync2_q;

endmodule

// File: rtl/random_target_gen.sv
// random_target_gen: draws a pseudo-random target in -99..+99 on a Start press
// and presents it in sign/BCD form for the guess comparator.
//   Clock        - system clock, rising edge
//   Reset        - asynchronous active-low reset
//   Start_button - raw active-low push-button
//   rdm1 / rdm0  - BCD tens / ones digit of the held target
//   neg          - target is negative (never set for zero)
//   ready        - a valid target is held
//   busy         - a draw is in progress
module random_target_gen
    import game_pkg::*;
#(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned MAX_MAG = MAX_MAG_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start_button,
    output logic [3:0] rdm0,
    output logic [3:0] rdm1,
    output logic       neg,
    output logic       ready,
    output logic       busy
);

    localparam logic [6:0] MaxMag = 7'(MAX_MAG);

    logic        start_evt;
    logic [15:0] lfsr_q;
    state_t      state_q, state_d;
    logic [6:0]  work_q, work_d;
    bcd_t        tens_q, tens_d;
    logic        sign_q, sign_d;
    bcd_t        rdm0_q, rdm1_q;
    logic        neg_q;
    logic        load_out;
    logic [6:0]  mag;
    logic        sgn;

    btn_sync_edge u_start_sync (
        .clk   (Clock),
        .rst_n (Reset),
        .btn   (Start_button),
        .fall  (start_evt)
    );

    // Free-running in every state so the target depends on press timing.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q, SEED);
        end
    end

    assign mag = lfsr_q[6:0];
    assign sgn = lfsr_q[7];

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        tens_d   = tens_q;
        sign_d   = sign_q;
        load_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_evt) state_d = StSample;
            end
            StSample: begin
                // Rejection sampling: out-of-range samples retry on the next LFSR value.
                if (mag <= MaxMag) begin
                    work_d  = mag;
                    tens_d  = 4'd0;
                    sign_d  = (mag != 7'd0) & sgn;
                    state_d = StConvert;
                end
            end
            StConvert: begin
                if (work_q >= 7'd10) begin
                    work_d = work_q - 7'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    load_out = 1'b1;
                    state_d  = StHold;
                end
            end
            StHold: begin
                if (start_evt) state_d = StSample;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            work_q  <= 7'd0;
            tens_q  <= 4'd0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            tens_q  <= tens_d;
            sign_q  <= sign_d;
        end
    end

    // Output digits update only on HOLD entry so the comparator never sees a partial value.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rdm0_q <= 4'd0;
            rdm1_q <= 4'd0;
            neg_q  <= 1'b0;
        end else if (load_out) begin
            rdm1_q <= tens_q;
            rdm0_q <= work_q[3:0];
            neg_q  <= sign_q;
        end
    end

    assign rdm0  = rdm0_q;
    assign rdm1  = rdm1_q;
    assign neg   = neg_q;
    assign ready = (state_q == StHold);
    assign busy  = (state_q == StSample) || (state_q == StConvert);

endmodule

// File: tb/tb_random_target_gen.sv
// tb_random_target_gen: directed self-checking bench for random_target_gen.
module tb_random_target_gen;
    import game_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       Clock;
    logic       Reset;
    logic       Start_button;
    logic [3:0] rdm0;
    logic [3:0] rdm1;
    logic       neg;
    logic       ready;
    logic       busy;

    int n_checks;
    int n_fail;
    logic [15:0] force_val;

    random_target_gen #(
        .SEED    (SEED),
        .MAX_MAG (99)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start_button (Start_button),
        .rdm0         (rdm0),
        .rdm1         (rdm1),
        .neg          (neg),
        .ready        (ready),
        .busy         (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_next(input logic [15:0] s);
        if (s == 16'h0000) return SEED;
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task force_on;
        force dut.lfsr_q = force_val;
    endtask

    task force_off;
        release dut.lfsr_q;
    endtask

    task automatic check_outputs(input string tag, input int r1, input int r0, input int ng);
        check({tag, "_rdm1"}, int'(rdm1), r1);
        check({tag, "_rdm0"}, int'(rdm0), r0);
        check({tag, "_neg"}, int'(neg), ng);
    endtask

    // Called at a negedge; returns how many rising edges until busy is seen.
    task automatic press_to_sample(output int lat);
        Start_button = 1'b0;
        lat = 0;
        do begin
            @(negedge Clock);
            lat++;
        end while (!busy && lat < 10);
    endtask

    task automatic draw_forced(input string tag, input logic [15:0] val, input int exp_lat,
                               input int r1, input int r0, input int ng);
        int lat;
        int n;
        int busy_cnt;
        press_to_sample(lat);
        check({tag, "_start_lat"}, lat, 3);
        force_val = val;
        force_on();
        @(posedge Clock);
        #1;
        force_off();
        n = 1;
        busy_cnt = 1;
        while (!ready && n < 20) begin
            busy_cnt += int'(busy);
            @(posedge Clock);
            #1;
            n++;
        end
        check({tag, "_ready_lat"}, n, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        check({tag, "_ready"}, int'(ready), 1);
        check_outputs(tag, r1, r0, ng);
        Start_button = 1'b1;
        repeat (4) @(negedge Clock);
    endtask

    initial begin
        logic [15:0] model;
        int lat;
        int n;
        int rises;
        int bad;
        logic prev_busy;

        n_checks     = 0;
        n_fail       = 0;
        force_val    = 16'h0000;
        Reset        = 1'b0;
        Start_button = 1'b1;

        // Reset state and LFSR sequence from SEED.
        repeat (2) @(negedge Clock);
        check_outputs("reset", 0, 0, 0);
        check("reset_ready", int'(ready), 0);
        check("reset_busy", int'(busy), 0);
        Reset = 1'b1;
        model = SEED;
        check("lfsr_seed", int'(dut.lfsr_q), int'(model));
        for (int i = 0; i < 1000; i++) begin
            @(posedge Clock);
            #1;
            model = model_next(model);
            check("lfsr_seq", int'(dut.lfsr_q), int'(model));
        end
        @(negedge Clock);

        // Directed draws: mag 87 positive, mag 99 negative.
        draw_forced("pos87", 16'h0057, 10, 8, 7, 0);
        draw_forced("neg99", 16'h00E3, 11, 9, 9, 1);

        // Rejection: 111 rejected, then 5 accepted; held target stays -99 meanwhile.
        press_to_sample(lat);
        check("rej_start_lat", lat, 3);
        force_val = 16'h006F;
        force_on();
        @(posedge Clock);
        #1;
        check("rej_still_sample", int'(busy), 1);
        check_outputs("rej_hold1", 9, 9, 1);
        force_off();
        force_val = 16'h0005;
        force_on();
        @(posedge Clock);
        #1;
        force_off();
        check_outputs("rej_hold2", 9, 9, 1);
        @(posedge Clock);
        #1;
        check("rej_ready", int'(ready), 1);
        check_outputs("rej", 0, 5, 0);
        Start_button = 1'b1;
        repeat (4) @(negedge Clock);

        // Zero with sign bit set must not produce -0.
        draw_forced("zero", 16'h0080, 2, 0, 0, 0);

        // Button held low for 500 cycles: exactly one draw.
        Start_button = 1'b0;
        rises = 0;
        prev_busy = busy;
        for (int i = 0; i < 500; i++) begin
            @(negedge Clock);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        check("held_draws", rises, 1);
        check("held_ready", int'(ready), 1);
        Start_button = 1'b1;
        repeat (4) @(negedge Clock);

        // Second press during CONVERT is ignored.
        press_to_sample(lat);
        force_val = 16'h0063;
        force_on();
        @(posedge Clock);
        #1;
        force_off();
        @(negedge Clock);
        Start_button = 1'b1;
        repeat (3) @(negedge Clock);
        Start_button = 1'b0;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("ignore_ready", int'(ready), 1);
        rises = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clock);
            rises += int'(busy);
        end
        check("ignore_no_redraw", rises, 0);
        check_outputs("ignore", 9, 9, 0);
        Start_button = 1'b1;
        repeat (4) @(negedge Clock);

        // Reset pulse mid-CONVERT clears outputs asynchronously.
        press_to_sample(lat);
        force_val = 16'h0063;
        force_on();
        @(posedge Clock);
        #1;
        force_off();
        repeat (2) @(negedge Clock);
        check("rstmid_busy_before", int'(busy), 1);
        #2;
        Reset = 1'b0;
        #1;
        check_outputs("rstmid", 0, 0, 0);
        check("rstmid_ready", int'(ready), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_state", int'(dut.state_q), int'(StIdle));
        @(negedge Clock);
        Start_button = 1'b1;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // Randomly timed presses: every target in range, both signs appear.
        begin
            int timeouts;
            int pos_seen;
            int neg_seen;
            timeouts = 0;
            pos_seen = 0;
            neg_seen = 0;
            bad = 0;
            for (int d = 0; d < 1500; d++) begin
                repeat ($urandom_range(0, 20)) @(negedge Clock);
                Start_button = 1'b0;
                n = 0;
                while (!busy && n < 10) begin
                    @(negedge Clock);
                    n++;
                end
                while (!ready && n < 300) begin
                    @(negedge Clock);
                    n++;
                end
                if (!ready) timeouts++;
                if (rdm1 > 4'd9 || rdm0 > 4'd9) bad++;
                if (neg && rdm1 == 4'd0 && rdm0 == 4'd0) bad++;
                if (neg) neg_seen = 1;
                else if (rdm1 != 4'd0 || rdm0 != 4'd0) pos_seen = 1;
                Start_button = 1'b1;
                repeat (3) @(negedge Clock);
            end
            check("rand_timeouts", timeouts, 0);
            check("rand_range", bad, 0);
            check("rand_pos_seen", pos_seen, 1);
            check("rand_neg_seen", neg_seen, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
